// File: rtl/hazard_detection.sv
// Stall/flush/freeze control for the 5-stage WISC pipeline, with a memory-wait timeout FSM.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_detection #(
  parameter int REG_W       = 4,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] IF_ID_RegRs,
  input  logic [REG_W-1:0] IF_ID_RegRt,
  input  logic             IF_ID_UsesRs,
  input  logic             IF_ID_UsesRt,
  input  logic             IF_ID_IsStore,
  input  logic             IF_ID_IsBranchReg,
  input  logic             Branch_Taken,
  input  logic             ID_EX_MemRead,
  input  logic             ID_EX_RegWrite,
  input  logic [REG_W-1:0] ID_EX_RegRd,
  input  logic             EX_MEM_MemRead,
  input  logic             EX_MEM_MemOp,
  input  logic [REG_W-1:0] EX_MEM_RegRd,
  input  logic             Mem_Ready,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             ID_EX_Bubble,
  output logic             IF_ID_Flush,
  output logic             Pipe_Freeze,
  output logic             Mem_Err,
  output logic [15:0]      Stall_Cnt,
  output logic [15:0]      Flush_Cnt
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     r_state;
  logic [7:0] r_wait_cnt;
  logic [7:0] w_wait_nxt;
  logic       w_load_use;
  logic       w_br_haz;
  logic       w_mem_busy;
  logic       w_hazard;

  // Store Rt is excluded: its value is consumed in MEM and reached by MEM-to-MEM forwarding.
  assign w_load_use = ID_EX_MemRead && (ID_EX_RegRd != '0) &&
                      ((IF_ID_UsesRs && (ID_EX_RegRd == IF_ID_RegRs)) ||
                       (IF_ID_UsesRt && !IF_ID_IsStore && (ID_EX_RegRd == IF_ID_RegRt)));

  assign w_br_haz = IF_ID_IsBranchReg &&
                    ((ID_EX_RegWrite && (ID_EX_RegRd != '0) && (ID_EX_RegRd == IF_ID_RegRs)) ||
                     (EX_MEM_MemRead && (EX_MEM_RegRd != '0) && (EX_MEM_RegRd == IF_ID_RegRs)));

  assign w_mem_busy = EX_MEM_MemOp && !Mem_Ready;
  assign w_hazard   = w_load_use || w_br_haz;
  assign w_wait_nxt = r_wait_cnt + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= RUN;
      r_wait_cnt <= 8'd0;
    end else if (r_state != ERROR) begin
      if (w_mem_busy) begin
        r_wait_cnt <= w_wait_nxt;
        r_state    <= (w_wait_nxt == TIMEOUT) ? ERROR : MEM_WAIT;
      end else begin
        r_wait_cnt <= 8'd0;
        r_state    <= RUN;
      end
    end
  end

  assign Mem_Err = (r_state == ERROR);

  always_comb begin
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Bubble = 1'b0;
    IF_ID_Flush  = 1'b0;
    Pipe_Freeze  = 1'b0;
    if (rst) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
    end else if (r_state == ERROR || w_mem_busy) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      Pipe_Freeze = 1'b1;
    end else if (w_hazard) begin
      // A stalled branch re-resolves next cycle, so Branch_Taken is ignored here.
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
    end else if (Branch_Taken) begin
      IF_ID_Flush = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;
  logic        w_stall_evt;
  logic        w_flush_evt;

  // Freeze and error cycles are excluded from both counts.
  assign w_stall_evt = (r_state != ERROR) && !w_mem_busy && w_hazard;
  assign w_flush_evt = IF_ID_Flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
    end else begin
      if (w_stall_evt && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_flush_evt && (r_flush_cnt != 16'hFFFF)) r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign Stall_Cnt = r_stall_cnt;
  assign Flush_Cnt = r_flush_cnt;
`else
  assign Stall_Cnt = 16'd0;
  assign Flush_Cnt = 16'd0;
`endif

endmodule

// File: doc/hazard_detection.md
# hazard_detection

Stall/flush control for the 5-stage WISC pipeline. It covers the cases the forwarding paths cannot repair by the time data is consumed:
- load-use hazards;
- register-sourced branches resolved in ID;
- data-memory wait states.

It sits beside the forwarding unit. It drives the PC write enable, the IF/ID write enable and flush, the ID/EX bubble, and the global freeze. It also runs a memory-wait state machine with timeout detection.

## Interface
- REG_W, 4, register-ID width.
- MEM_TIMEOUT, 255, consecutive not-ready memory cycles before error (1..255).

- clk  in  1  core clock.
- rst  in  1  reset, asynchronous, active-high.
- IF_ID_RegRs, IF_ID_RegRt  in  REG_W  source registers of the instruction in ID.
- IF_ID_UsesRs, IF_ID_UsesRt  in  1  instruction in ID reads that source.
- IF_ID_IsStore  in  1  ID instruction is a store; its Rt is consumed in MEM.
- IF_ID_IsBranchReg  in  1  ID instruction is a branch reading Rs in ID.
- Branch_Taken  in  1  branch in ID resolved taken.
- ID_EX_MemRead, ID_EX_RegWrite  in  1  EX-stage instruction is a load / writes a register.
- ID_EX_RegRd  in  REG_W  EX-stage destination.
- EX_MEM_MemRead, EX_MEM_MemOp  in  1  MEM-stage instruction is a load / any memory access.
- EX_MEM_RegRd  in  REG_W  MEM-stage destination.
- Mem_Ready  in  1  data memory completes the access this cycle.
- PC_Write, IF_ID_Write  out  1  update enables.
- ID_EX_Bubble  out  1  load NOP into ID/EX.
- IF_ID_Flush  out  1  squash the IF/ID contents.
- Pipe_Freeze  out  1  every pipeline register holds.
- Mem_Err  out  1  sticky memory timeout.
- Stall_Cnt, Flush_Cnt  out  16  performance counters.

## Operation
Hazard terms (register 0 never hazards):
- **load_use** = ID_EX_MemRead & ID_EX_RegRd!=0 & ((UsesRs & Rd==Rs) | (UsesRt & !IsStore & Rd==Rt)).
  - Store Rt is excluded because MEM-to-MEM forwarding covers it.
- **br_haz** = IsBranchReg & ((ID_EX_RegWrite & ID_EX_RegRd!=0 & ID_EX_RegRd==Rs) | (EX_MEM_MemRead & EX_MEM_RegRd!=0 & EX_MEM_RegRd==Rs)).
  - A load ahead produces a 2-cycle stall.
- **mem_busy** = EX_MEM_MemOp & !Mem_Ready.

States:
- **RUN**: wait_cnt==0.
- **MEM_WAIT**: wait_cnt!=0.
- **ERROR**.

Outputs in RUN/MEM_WAIT, by priority:
1. **mem_busy**: Pipe_Freeze=1, PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=0, IF_ID_Flush=0.
2. **load_use | br_haz**: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=0. Branch_Taken is ignored; the branch re-resolves after the stall.
3. **Branch_Taken**: IF_ID_Flush=1, PC_Write=1, IF_ID_Write=1.
4. **Otherwise**: PC_Write=1, IF_ID_Write=1, all others 0.

Outputs in ERROR:
- Pipe_Freeze=1, Mem_Err=1, PC_Write=0, IF_ID_Write=0.
- Held until rst.

Outputs while rst is high: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1, all other outputs 0.

## Timing
- All hazard/control outputs are combinational from the current inputs and state. Zero latency: the stall applies in the same cycle the hazard is visible.
- wait_cnt is 8 bits. At each rising edge:
  - if mem_busy: wait_cnt+1. If that value equals MEM_TIMEOUT, the next state is ERROR.
  - else: wait_cnt=0, state RUN.
- Mem_Ready high in the first cycle of an access: no freeze, and the state stays RUN.
- Mem_Ready rising on the cycle the count would reach MEM_TIMEOUT: the access completes and ERROR is not entered.
- Async rst at any point (mid-stall, MEM_WAIT, ERROR): state RUN, wait_cnt=0, Mem_Err=0, counters=0 immediately.
- After rst deasserts, the first edge behaves as RUN.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - Stall_Cnt increments on each edge where (load_use|br_haz) stall is output.
  - Flush_Cnt increments on each edge where IF_ID_Flush=1.
  - Both saturate at 16'hFFFF.
  - Freeze cycles are not counted.
- Not defined: the counter registers are omitted, and Stall_Cnt and Flush_Cnt are tied to 0.

## Test plan
- Load R3 in EX, ID reads Rs=3 → 1 cycle with PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1; next cycle all normal. The same case with Rd=0 → no stall.
- Store in ID with Rt=3, load R3 in EX → no stall. Rs=3 instead → stall.
- Reg-branch Rs=5 with load R5 in EX → 2 stall cycles. Branch_Taken asserted during the stall → IF_ID_Flush=0; flush asserts only in the first non-stall cycle.
- MemOp with Mem_Ready low for 3 cycles → Pipe_Freeze=1 for exactly 3 cycles, ID_EX_Bubble=0; wait_cnt returns to 0.
- MEM_TIMEOUT=4, Mem_Ready held low → ERROR after the 4th edge: Mem_Err=1 sticky. Async rst mid-ERROR → Mem_Err=0 without a clock edge.
- With HAZARD_PERF_CNT_EN: 2 load-use stalls + 1 taken branch → Stall_Cnt=2, Flush_Cnt=1. Preload the counters near saturation (forced) → they hold at 16'hFFFF.
